snes_multi_ctrl: RTL and testbench
==================================

Name: snes_multi_ctrl

Overview:
Parametrised serial game-pad reader. It polls NPORT NES/SNES-style controllers that share one latch line and one clock line, each with its own data line. It shifts NBITS+1 bits per port and publishes active-high button words plus a per-port presence flag. Polls start on a one-shot request or automatically at a fixed period. It sits between the board pad connectors and the input-mapping logic.

Parameters:
SYSMHZ, 100, system clock frequency in MHz.
TICKUS, 6, protocol tick period in µs. DIV = SYSMHZ*TICKUS; DIV must be >= 2.
NPORT, 2, number of controller ports (1..4).
NBITS, 16, button bits per port: 8 for NES, 12 or 16 for SNES (2..32).
AUTOTICKS, 2778, ticks between automatic polls (about 60 Hz at the defaults).

Ports:
clk  in  1  system clock; the block's only clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle poll request.
auto_en  in  1  level; enables periodic polling.
data  in  NPORT  raw serial data, one bit per port; asynchronous to clk.
dclk  out  1  controller clock; idles high.
dlatch  out  1  controller latch; active high.
buttons  out  NPORT*NBITS  pressed=1. Port p occupies [p*NBITS +: NBITS]; first-shifted bit is at index 0.
present  out  NPORT  1 if a controller was detected on that port in the last poll.
valid  out  1  one-cycle pulse when buttons/present update.
busy  out  1  high while a poll is pending or in progress.

Behaviour:
- Reset (async assert, sync release): all state cleared. State=IDLE. dclk=1, dlatch=0, buttons=0, present=0, valid=0, busy=0, pending=0. Tick divider and auto counter = 0.
- Input sync: each data bit passes through two clk flops before it is used.
- Tick divider: counts 0..DIV-1 and wraps. tick=1 for one clk cycle when the count equals DIV-1. The first tick arrives DIV cycles after reset release. All FSM transitions happen only on tick cycles.
- Auto counter: advances on each tick and wraps at AUTOTICKS-1. On the wrap tick, if auto_en=1, pending is set.
- start: sets pending on any cycle, including while busy. At most one request is queued; additional requests are merged into it.
- dclk and dlatch are registered outputs, driven directly from state.
- FSM (idx counts 0..NBITS):
  - IDLE: dclk=1, dlatch=0. On a tick with pending=1: clear pending, set idx=0, go to LAT0. A start arriving in that same cycle leaves pending=1.
  - LAT0 -> LAT1: dlatch=1, one tick each.
  - SAMP: dclk=1, dlatch=0. On tick, shift the synchronised data[p] into raw shift register p at position idx. If idx==NBITS go to DONE; otherwise idx++ and go to CLKLO.
  - CLKLO: dclk=0 for one tick, then go to SAMP.
  - DONE: on tick, buttons[p] = ~raw[p][NBITS-1:0] and present[p] = ~raw[p][NBITS]. Pulse valid for exactly that one clk cycle. Go to IDLE.
- One poll therefore has NBITS+1 samples and NBITS dclk low pulses. Sample NBITS is the extra bit: a connected controller drives it 0, while an open pulled-up line reads 1.
- Latency from leaving IDLE to valid = 2*NBITS+4 ticks. Add up to 1 tick of wait in IDLE.
- busy = (state != IDLE) | pending.
- Between polls, buttons and present hold their values. An open port reports buttons=0 and present=0.
- If rst_n is asserted mid-poll, the poll aborts immediately: outputs return to reset values, there is no valid pulse, and the queued request is lost.

Test Plan:
1. SYSMHZ=2, TICKUS=1, NBITS=8, NPORT=2. Port0 model presents raw 0b11111110 then extra 0; port1 is tied high. Pulse start -> 8 dclk low pulses and dlatch high for 2 ticks. valid arrives 20 ticks after leaving IDLE. buttons=0x00_01 and present=2'b01.
2. NBITS=16, port0 raw 16'h7FFE then extra 0 -> buttons[15:0]=16'h8001 and present[0]=1. Raw bit order is checked against the index mapping.
3. Pulse start three times during a poll -> exactly one further poll follows, giving exactly 2 valid pulses in total. busy drops after the second valid.
4. auto_en=1, AUTOTICKS=50, DIV=2, no start -> valid pulses every 50 ticks (100 clk cycles). Deassert auto_en -> no further polls.
5. Assert rst_n low during CLKLO on bit 5 -> dclk=1, dlatch=0, buttons=0 and busy=0 immediately; no valid pulse after release.
6. Change data asynchronously in the middle of a tick period -> the sampled value equals the synchronised level at the sample tick; no X propagates.

Source files
------------

// File: rtl/snes_multi_ctrl.sv
// snes_multi_ctrl: polls NPORT NES/SNES pads sharing latch and clock lines.
// Each poll shifts NBITS button bits plus one presence bit per port and
// publishes active-high button words with a one-cycle valid strobe.
module snes_multi_ctrl #(
    parameter int SYSMHZ    = 100,
    parameter int TICKUS    = 6,
    parameter int NPORT     = 2,
    parameter int NBITS     = 16,
    parameter int AUTOTICKS = 2778
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [NPORT-1:0]         data,
    output logic                     dclk,
    output logic                     dlatch,
    output logic [NPORT*NBITS-1:0]   buttons,
    output logic [NPORT-1:0]         present,
    output logic                     valid,
    output logic                     busy
);

    localparam int DIV   = SYSMHZ * TICKUS;
    localparam int DIVW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AUTOW = (AUTOTICKS > 1) ? $clog2(AUTOTICKS) : 1;
    localparam int IDXW  = $clog2(NBITS + 1);

    localparam logic [DIVW-1:0]  DIV_LAST  = DIVW'(DIV - 1);
    localparam logic [AUTOW-1:0] AUTO_LAST = AUTOW'(AUTOTICKS - 1);
    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LAT0  = 3'd1,
        S_LAT1  = 3'd2,
        S_SAMP  = 3'd3,
        S_CLKLO = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    logic [NPORT-1:0]  r_data_meta;
    logic [NPORT-1:0]  r_data_sync;
    logic [DIVW-1:0]   r_div_cnt;
    logic [AUTOW-1:0]  r_auto_cnt;
    logic              r_pending;
    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_dclk;
    logic              r_dlatch;
    logic              r_valid;
    logic [NBITS:0]    r_raw     [NPORT];
    logic [NBITS-1:0]  r_btn     [NPORT];
    logic              r_pres    [NPORT];

    state_t            w_state_next;
    logic [IDXW-1:0]   w_idx_next;
    logic              w_tick;
    logic              w_auto_wrap;
    logic              w_take;
    logic              w_shift;
    logic              w_publish;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_auto_wrap = w_tick && (r_auto_cnt == AUTO_LAST);

    // Two-flop synchroniser for the asynchronous pad data lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_meta <= '0;
            r_data_sync <= '0;
        end else begin
            r_data_meta <= data;
            r_data_sync <= r_data_meta;
        end
    end

    // Protocol tick divider: one-cycle tick every DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIVW'(1);
        end
    end

    // Free-running auto-poll period counter, advancing once per tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (w_tick) begin
            if (r_auto_cnt == AUTO_LAST) begin
                r_auto_cnt <= '0;
            end else begin
                r_auto_cnt <= r_auto_cnt + AUTOW'(1);
            end
        end
    end

    // Single-entry request queue; a new request wins over the consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_take) | start | (w_auto_wrap & auto_en);
        end
    end

    // Next-state logic; every transition waits for a tick
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_take       = 1'b0;
        w_shift      = 1'b0;
        w_publish    = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        w_take       = 1'b1;
                        w_idx_next   = '0;
                        w_state_next = S_LAT0;
                    end
                end
                S_LAT0:  w_state_next = S_LAT1;
                S_LAT1:  w_state_next = S_SAMP;
                S_SAMP: begin
                    w_shift = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_idx_next   = r_idx + IDXW'(1);
                        w_state_next = S_CLKLO;
                    end
                end
                S_CLKLO: w_state_next = S_SAMP;
                S_DONE: begin
                    w_publish    = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State, bit index and registered pad-line / strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_dclk   <= 1'b1;
            r_dlatch <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_dclk   <= (w_state_next != S_CLKLO);
            r_dlatch <= (w_state_next == S_LAT0) || (w_state_next == S_LAT1);
            r_valid  <= w_publish;
        end
    end

    // Per-port shift register and published button/presence words
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            // Capture sample idx, then invert into active-high outputs on DONE
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_raw[gi]  <= '0;
                    r_btn[gi]  <= '0;
                    r_pres[gi] <= 1'b0;
                end else begin
                    if (w_shift) begin
                        r_raw[gi][r_idx] <= r_data_sync[gi];
                    end
                    if (w_publish) begin
                        r_btn[gi]  <= ~r_raw[gi][NBITS-1:0];
                        r_pres[gi] <= ~r_raw[gi][NBITS];
                    end
                end
            end
            assign buttons[gi*NBITS +: NBITS] = r_btn[gi];
            assign present[gi]                = r_pres[gi];
        end
    endgenerate

    assign dclk   = r_dclk;
    assign dlatch = r_dlatch;
    assign valid  = r_valid;
    assign busy   = (r_state != S_IDLE) | r_pending;

endmodule

// File: tb/tb_snes_multi_ctrl.sv
// Self-checking bench for snes_multi_ctrl with behavioural pad models.
module tb_snes_multi_ctrl;

    localparam int NPORT    = 2;
    localparam int NBITS    = 16;
    localparam int DIV      = 4;     // SYSMHZ=4, TICKUS=1
    localparam int AUTOT    = 50;
    localparam int POLL_CYC = (2*NBITS + 4) * DIV;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   auto_en = 1'b0;
    logic [NPORT-1:0]       data;
    logic                   dclk;
    logic                   dlatch;
    logic [NPORT*NBITS-1:0] buttons;
    logic [NPORT-1:0]       present;
    logic                   valid;
    logic                   busy;

    always #5 clk = ~clk;

    snes_multi_ctrl #(
        .SYSMHZ(4), .TICKUS(1), .NPORT(NPORT), .NBITS(NBITS), .AUTOTICKS(AUTOT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .data(data),
        .dclk(dclk), .dlatch(dlatch), .buttons(buttons), .present(present),
        .valid(valid), .busy(busy)
    );

    // Pad model: a pressed button reads 0, the extra bit reads 0 when connected.
    logic [NBITS:0]   pad_raw  [NPORT];
    logic             pad_conn [NPORT];
    logic             pad_bit  [NPORT];
    logic [NBITS-1:0] exp_btn  [NPORT];
    logic             exp_pres [NPORT];

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_pad
            int pos;
            assign data[gi] = pad_bit[gi];
            // Latch reloads bit 0, each rising dclk advances; output settles
            // at a random point inside the tick, off the clock edges.
            initial begin
                pos = 0;
                pad_bit[gi] = 1'b1;
                forever begin
                    @(posedge dclk or posedge dlatch);
                    #(1 + $urandom_range(0, 3) + 5 * $urandom_range(0, 2));
                    if (dlatch) pos = 0;
                    else if (pos < NBITS) pos++;
                    pad_bit[gi] = pad_conn[gi] ? pad_raw[gi][pos] : 1'b1;
                end
            end
        end
    endgenerate

    // Activity monitor
    int   cyc = 0, valid_cnt = 0, dclk_falls = 0;
    int   latch_cyc = 0, latch_len = 0, last_valid_cyc = 0;
    logic dclk_q = 1'b1, dlatch_q = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (dlatch && !dlatch_q) begin
            latch_cyc = cyc;
            latch_len = 0;
        end
        if (dlatch) latch_len++;
        if (!dclk && dclk_q) dclk_falls++;
        dclk_q   = dclk;
        dlatch_q = dlatch;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_pad(input int p, input logic conn, input logic [NBITS-1:0] mask);
        pad_conn[p] = conn;
        pad_raw[p]  = {1'b0, ~mask};
        exp_btn[p]  = conn ? mask : '0;
        exp_pres[p] = conn;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            step();
            n++;
            if (valid === 1'b1) got = 1'b1;
        end
        check({tag, "_valid_seen"}, 64'(got), 64'd1);
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NPORT; p++) begin
            check($sformatf("%s_btn%0d", tag, p), 64'(buttons[p*NBITS +: NBITS]), 64'(exp_btn[p]));
            check($sformatf("%s_pres%0d", tag, p), 64'(present[p]), 64'(exp_pres[p]));
        end
        check({tag, "_noX"}, 64'($isunknown({buttons, present})), 64'd0);
        $display("%s: buttons=%h present=%b", tag, buttons, present);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, a1, a2, n;

        // Reset state
        set_pad(0, 1'b1, 16'h8001);
        set_pad(1, 1'b0, 16'h0000);
        repeat (3) step();
        check("rst_dclk", 64'(dclk), 64'd1);
        check("rst_dlatch", 64'(dlatch), 64'd0);
        check("rst_buttons", 64'(buttons), 64'd0);
        check("rst_present", 64'(present), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (20) step();
        check("idle_busy", 64'(busy), 64'd0);

        // Directed poll: raw 7FFE + extra 0 on port 0, port 1 open
        v0 = valid_cnt;
        f0 = dclk_falls;
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        wait_valid("poll1", 400);
        check("poll1_latency", 64'(last_valid_cyc - latch_cyc), 64'(POLL_CYC));
        check("poll1_latch_len", 64'(latch_len), 64'(2 * DIV));
        check("poll1_dclk_pulses", 64'(dclk_falls - f0), 64'(NBITS));
        check_outputs("poll1");
        step();
        check("poll1_valid_width", 64'(valid), 64'd0);
        check("poll1_busy_after", 64'(busy), 64'd0);
        check("poll1_valid_count", 64'(valid_cnt - v0), 64'd1);

        // Randomised polls against the pad model
        for (int i = 0; i < 6; i++) begin
            set_pad(0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), NBITS'($urandom));
            set_pad(1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), NBITS'($urandom));
            repeat ($urandom_range(0, 7)) step();
            pulse_start();
            wait_valid($sformatf("rand%0d", i), 400);
            check_outputs($sformatf("rand%0d", i));
        end

        // Multiple starts during a poll merge into one follow-up poll
        set_pad(0, 1'b1, 16'h0F0F);
        set_pad(1, 1'b1, 16'hF00F);
        v0 = valid_cnt;
        pulse_start();
        repeat (20) step();
        pulse_start();
        repeat (5) step();
        pulse_start();
        repeat (30) step();
        pulse_start();
        wait_valid("merge_a", 400);
        wait_valid("merge_b", 400);
        check("merge_busy_after", 64'(busy), 64'd0);
        check_outputs("merge");
        repeat (400) step();
        check("merge_valid_count", 64'(valid_cnt - v0), 64'd2);

        // Automatic polling at AUTOT ticks
        set_pad(0, 1'b1, 16'hA5C3);
        set_pad(1, 1'b1, 16'h1234);
        auto_en = 1'b1;
        wait_valid("auto0", 600);
        a1 = last_valid_cyc;
        check_outputs("auto0");
        wait_valid("auto1", 400);
        a2 = last_valid_cyc;
        check("auto_period1", 64'(a2 - a1), 64'(AUTOT * DIV));
        wait_valid("auto2", 400);
        check("auto_period2", 64'(last_valid_cyc - a2), 64'(AUTOT * DIV));
        auto_en = 1'b0;
        v0 = valid_cnt;
        repeat (600) step();
        check("auto_off_count", 64'(valid_cnt - v0), 64'd0);
        check("auto_off_busy", 64'(busy), 64'd0);

        // Reset during CLKLO of bit 5 aborts the poll and drops the queue
        f0 = dclk_falls;
        v0 = valid_cnt;
        pulse_start();
        n = 0;
        while (n < 400 && (dclk_falls - f0) < 5) begin
            step();
            n++;
        end
        check("abort_reached_bit5", 64'(dclk_falls - f0), 64'd5);
        pulse_start();
        check("abort_pre_dclk", 64'(dclk), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_dclk", 64'(dclk), 64'd1);
        check("abort_dlatch", 64'(dlatch), 64'd0);
        check("abort_buttons", 64'(buttons), 64'd0);
        check("abort_present", 64'(present), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (600) step();
        check("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
        check("abort_busy_after", 64'(busy), 64'd0);
        check("abort_buttons_after", 64'(buttons), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
